// File: rtl/insn_mem_resp.sv
// insn_mem_resp
//
// Instruction-memory responder on the fetch side of the IF/ID register.
// It accepts a fetch byte address, waits LATENCY cycles, and then returns
// the 32-bit instruction held in a word-addressed store. While a fetch is
// outstanding, busy stalls the pipeline. A separate load port fills the
// store before or between runs.
//
// Parameters
//   DEPTH_W  word-address width; the store holds 2**DEPTH_W words
//   LATENCY  wait states per fetch (0..15)
//   ISA_NOP  instruction returned on error, flush and reset (addi x0,x0,0)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-low
//   pc          fetch byte address, qualified by req
//   req         fetch request
//   flush       abort any outstanding or requested fetch (beats req)
//   ld_en       program-load write enable
//   ld_addr     program-load word address
//   ld_data     program-load data
//   insn        registered instruction; holds between responses
//   insn_valid  one-cycle pulse: insn and err are valid
//   busy        combinational stall request
//   err         the response was for a misaligned or out-of-range address
//
// Handshake: the pipeline raises req with pc, and the fetch is accepted in
// that same cycle if the block is in IDLE or RESP and flush is low. busy then
// stays high until the response cycle. insn_valid pulses for exactly one
// cycle, and the pipeline must take insn/err then, because there is no
// back-pressure on the response.
module insn_mem_resp #(
    parameter int unsigned DEPTH_W = 10,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] ISA_NOP = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic               req,
    input  logic               flush,
    input  logic               ld_en,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [31:0]        ld_data,
    output logic [31:0]        insn,
    output logic               insn_valid,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] addr_q;
    logic [3:0]  cnt;
    logic        accept;
    logic        addr_bad;

    logic [31:0] mem [0:(1 << DEPTH_W) - 1];

    // A new fetch may start from IDLE or from the response cycle, which is
    // what gives back-to-back fetches with no idle gap.
    assign accept = (state == ST_IDLE || state == ST_RESP) && req && !flush;

    // Misaligned, or any address bit above the store's byte range is set.
    assign addr_bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_W + 2)) != 32'd0);

    // Both outputs are held low while reset is asserted. Reset is synchronous,
    // so without this gating they would follow the pre-reset state for a
    // cycle.
    assign busy       = reset && !flush &&
                        ((state == ST_WAIT) ||
                         ((state == ST_IDLE || state == ST_RESP) && req));
    assign insn_valid = reset && (state == ST_RESP);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
            ST_RESP: next_state = accept ? ST_WAIT : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            addr_q <= 32'd0;
            insn   <= ISA_NOP;
            err    <= 1'b0;
        end else begin
            state <= next_state;
            if (flush) begin
                cnt  <= 4'd0;
                insn <= ISA_NOP;
                err  <= 1'b0;
            end else if (accept) begin
                addr_q <= pc;
                cnt    <= 4'(LATENCY);
            end else if (state == ST_WAIT) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (addr_bad) begin
                    insn <= ISA_NOP;
                    err  <= 1'b1;
                end else begin
                    // Non-blocking read, so a load to the same word at this
                    // edge is seen only by later fetches (read-before-write).
                    insn <= mem[addr_q[DEPTH_W+1:2]];
                    err  <= 1'b0;
                end
            end
        end
    end

    // Store contents are not reset, and loads are ignored while reset is
    // asserted.
    always_ff @(posedge clk) begin
        if (reset && ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_insn_mem_resp.sv
module tb_insn_mem_resp;

    localparam int unsigned DEPTH_W = 10;
    localparam int unsigned LAT     = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic               clk;
    logic               reset;
    logic [31:0]        pc;
    logic               req;
    logic               flush;
    logic               ld_en;
    logic [DEPTH_W-1:0] ld_addr;
    logic [31:0]        ld_data;
    logic [31:0]        insn;
    logic               insn_valid;
    logic               busy;
    logic               err;

    int tests_run;
    int tests_failed;

    // Expected responses as {err, insn}, pushed when a fetch is issued.
    logic [32:0] exp_q[$];

    insn_mem_resp #(
        .DEPTH_W(DEPTH_W),
        .LATENCY(LAT),
        .ISA_NOP(NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .req       (req),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .insn      (insn),
        .insn_valid(insn_valid),
        .busy      (busy),
        .err       (err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response the DUT presents is popped and compared.
    always @(negedge clk) begin
        if (insn_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_valid: got insn %h err %b expected no response (t=%0t)",
                         insn, err, $time);
            end else begin
                check("response", {err, insn}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DEPTH_W-1:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        next_cycle();
        ld_en   = 1'b0;
    endtask

    // One complete fetch from IDLE. An optional load is driven in the last
    // wait cycle, so that it lands on the same edge as the read.
    task automatic run_fetch(input logic [31:0] a, input logic [32:0] e,
                             input bit do_ld, input logic [DEPTH_W-1:0] la,
                             input logic [31:0] ld);
        req = 1'b1;
        pc  = a;
        exp_q.push_back(e);
        for (int i = 0; i <= int'(LAT) + 1; i++) begin
            if (do_ld && i == int'(LAT) + 1) begin
                ld_en   = 1'b1;
                ld_addr = la;
                ld_data = ld;
            end
            @(negedge clk);
            check("fetch_busy", 33'(busy), 33'd1);
            check("fetch_no_early_valid", 33'(insn_valid), 33'd0);
            next_cycle();
            req   = 1'b0;
            pc    = $urandom;
            ld_en = 1'b0;
        end
        @(negedge clk);
        check("fetch_valid_cycle", 33'(insn_valid), 33'd1);
        check("fetch_busy_released", 33'(busy), 33'd0);
        next_cycle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        req     = 1'b1;
        pc      = 32'h4;
        flush   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;

        // Reset held for two cycles with req high
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            check("reset_insn", {1'b0, insn}, {1'b0, NOP});
            check("reset_valid", 33'(insn_valid), 33'd0);
            check("reset_busy", 33'(busy), 33'd0);
            check("reset_err", 33'(err), 33'd0);
        end
        next_cycle();
        reset = 1'b1;
        req   = 1'b0;

        load_word(10'd1, 32'h124);
        load_word(10'd2, 32'h154);

        // Basic fetch of word 1
        run_fetch(32'h4, {1'b0, 32'h124}, 1'b0, '0, '0);

        // Flush in c2 of a fetch to 0x8
        req = 1'b1;
        pc  = 32'h8;
        @(negedge clk);
        check("flush_c0_busy", 33'(busy), 33'd1);
        next_cycle();
        req = 1'b0;
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("flush_c2_busy", 33'(busy), 33'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_c3_insn", {err, insn}, {1'b0, NOP});
        check("flush_c3_busy", 33'(busy), 33'd0);
        for (int i = 4; i <= 6; i++) begin
            next_cycle();
            @(negedge clk);
            check("flush_no_valid", 33'(insn_valid), 33'd0);
        end
        next_cycle();

        // Error addresses: misaligned, then just past the top of the store
        run_fetch(32'h6, {1'b1, NOP}, 1'b0, '0, '0);
        run_fetch(32'h1000, {1'b1, NOP}, 1'b0, '0, '0);
        // Last in-range word is not an error and returns the load data
        load_word(10'h3FF, 32'hCAFE_F00D);
        run_fetch(32'hFFC, {1'b0, 32'hCAFE_F00D}, 1'b0, '0, '0);

        // Back-to-back fetches: 0x4, then 0x8 accepted in the RESP cycle
        req = 1'b1;
        pc  = 32'h4;
        exp_q.push_back({1'b0, 32'h124});
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 1) pc = 32'hDEAD_BEE0;
            if (c == 4) begin
                pc = 32'h8;
                exp_q.push_back({1'b0, 32'h154});
            end
            if (c == 5) pc = 32'h0000_0FF0;
            if (c == 8) req = 1'b0;
            @(negedge clk);
            check("b2b_valid", 33'(insn_valid), (c == 4 || c == 8) ? 33'd1 : 33'd0);
            check("b2b_busy", 33'(busy), (c == 8) ? 33'd0 : 33'd1);
        end
        next_cycle();

        // Reset asserted in c2 of a fetch
        req = 1'b1;
        pc  = 32'h4;
        next_cycle();
        req = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 33'(busy), 33'd0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_insn", {err, insn}, {1'b0, NOP});
        check("midrst_busy_after", 33'(busy), 33'd0);
        for (int i = 4; i <= 6; i++) begin
            next_cycle();
            @(negedge clk);
            check("midrst_no_valid", 33'(insn_valid), 33'd0);
        end
        next_cycle();
        run_fetch(32'h4, {1'b0, 32'h124}, 1'b0, '0, '0);

        // Load to word 1 on the same edge as the read returns the old data,
        // and the following fetch sees the new data.
        run_fetch(32'h4, {1'b0, 32'h124}, 1'b1, 10'd1, 32'h0BAD_C0DE);
        run_fetch(32'h4, {1'b0, 32'h0BAD_C0DE}, 1'b0, '0, '0);

        repeat (3) next_cycle();
        check("all_responses_seen", 33'(exp_q.size()), 33'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/insn_mem_resp.md
# insn_mem_resp

Instruction-memory responder on the fetch side of the IF/ID pipeline register. It accepts the fetch address the IF register drives and returns the 32-bit instruction after a fixed, parameterised number of wait states. While a fetch is outstanding it asserts `busy` so the pipeline stalls. It also exposes a program-load write port used to fill the instruction store before or between runs.

## Interface
- `DEPTH_W`, default 10: word-address width; the store holds 2^DEPTH_W 32-bit words.
- `LATENCY`, default 2: wait states per fetch; legal range 0–15.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; `reset`=0 sampled at a rising edge resets the block.
- `pc` in 32: fetch byte address from the IF/ID register.
- `req` in 1: fetch request; `pc` is valid when `req`=1.
- `flush` in 1: cancel any outstanding or requested fetch.
- `ld_en` in 1: program-load write enable.
- `ld_addr` in DEPTH_W: program-load word address.
- `ld_data` in 32: program-load data.
- `insn` out 32: returned instruction; registered; holds its value between responses.
- `insn_valid` out 1: `insn` and `err` are valid this cycle (one-cycle pulse).
- `busy` out 1: combinational stall request to the pipeline.
- `err` out 1: response was for a misaligned or out-of-range address; qualified by `insn_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP. Internal state: `addr_q` (32 bits) and `cnt` (4 bits).
- **IDLE**
  - If `req`=1 and `flush`=0: latch `pc` into `addr_q`, set `cnt`=LATENCY, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - While `cnt`≠0: decrement `cnt` each cycle.
  - When `cnt`=0: load `insn`, load `err`, go to RESP.
  - A misaligned address (`addr_q[1:0]`≠0) or out-of-range address (any bit of `addr_q[31:DEPTH_W+2]` set) loads `insn`=`ISA_NOP` and `err`=1.
  - Otherwise load `insn`=mem[`addr_q[DEPTH_W+1:2]`] and `err`=0.
- **RESP**
  - `insn_valid`=1 for this one cycle.
  - If `req`=1 and `flush`=0: accept the new `pc` exactly as in IDLE (back-to-back fetch).
  - Otherwise go to IDLE.
- `busy` = (`flush`=0) and ((state=WAIT) or (state∈{IDLE,RESP} and `req`=1)).
- **flush**=1 (any state): next state IDLE, `insn`←`ISA_NOP`, `err`←0, no `insn_valid` for the aborted fetch. Flush has priority over `req`.
- **Load port**: `ld_en`=1 writes `ld_data` to mem[`ld_addr`] at the edge. Loads are independent of FSM state, flush and `req`.
- **Same-edge read and write to one word**: the read returns the old data (read-before-write).
- **Reset** (`reset`=0 at an edge), from any state including mid-WAIT: state IDLE, `cnt`=0, `addr_q`=0, `insn`=`ISA_NOP`, `insn_valid`=0, `err`=0. `busy` is 0 during reset. Memory contents are not reset; a load while `reset`=0 is ignored.

## Timing
- Acceptance cycle c0: `req`=1 sampled in IDLE or RESP.
- `busy`=1 in cycles c0 … c0+LATENCY+1.
- `insn_valid`=1 in cycle c0+LATENCY+2 only.
- With LATENCY=0: valid in c0+2.
- Back-to-back throughput: one fetch per LATENCY+2 cycles.
- `insn` changes only at the WAIT→RESP edge, on flush, or on reset. Between those events it holds its value.
- The `pc` change between fetches is taken only at acceptance. Changes to `pc` during WAIT are ignored.
- `cnt` never wraps: it stops at 0 on the transition out of WAIT.

## Test plan
- **Reset**: `reset`=0 for 2 cycles with `req`=1 → `insn`=`ISA_NOP`, `insn_valid`=0, `busy`=0, `err`=0.
- **Basic fetch** (LATENCY=2): load mem[1]=32'h124, then `req`=1, `pc`=32'h4 at c0 → `busy`=1 in c0–c3; c4 has `insn_valid`=1, `insn`=32'h124, `err`=0; `busy`=0 in c4 once `req` drops.
- **Flush**: `pc`=32'h8 accepted at c0, `flush`=1 in c2 → `busy`=0 in c2; IDLE and `insn`=`ISA_NOP` in c3; `insn_valid` stays 0 through c6.
- **Error addresses**:
  - `pc`=32'h6 → response with `insn`=`ISA_NOP`, `err`=1, `insn_valid`=1.
  - `pc`=32'h1000 (DEPTH_W=10) → same response.
- **Back-to-back**: mem[1]=32'h124, mem[2]=32'h154; hold `req`=1, `pc`=32'h4, then switch to 32'h8 in the RESP cycle → valid pulses at c4 (32'h124) and c8 (32'h154).
- **Reset mid-fetch**: `reset`=0 in c2 of a fetch → IDLE, no `insn_valid`. The next fetch of 32'h4 completes normally with 32'h124.
